// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH window extractor: channel count default,
// per-channel window state, counter width and the context record.
package prach_pkg;

  localparam int PRACH_NUM_CHN = 8;
  localparam int CNT_W         = 16;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_PASS = 2'd2,
    ST_DONE = 2'd3
  } win_state_e;

  typedef struct packed {
    win_state_e       state;
    logic [CNT_W-1:0] skip;
    logic [CNT_W-1:0] rem;
  } chn_ctx_t;

  // Context a channel takes on at frame start; disabled channels stay idle.
  function automatic chn_ctx_t load_ctx(input logic             en,
                                        input logic [CNT_W-1:0] offset,
                                        input logic [CNT_W-1:0] length);
    chn_ctx_t ctx;
    ctx = '0;
    if (en) begin
      ctx.state = ST_SKIP;
      ctx.skip  = offset;
      ctx.rem   = length;
    end
    return ctx;
  endfunction

endpackage

// File: rtl/prach_window.sv
// PRACH window extractor: for each TDM channel, skips a programmable number
// of samples after frame sync and then forwards a programmable-length window.
// Stage 1 does the context read-modify-write, stage 2 registers the outputs.
module prach_window
  import prach_pkg::*;
#(
  parameter int NUM_CHN = PRACH_NUM_CHN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [15:0]      din_dr,
  input  logic signed [15:0]      din_di,
  input  logic                    din_dv,
  input  logic [7:0]              din_chn,
  input  logic                    sync_in,
  output logic signed [15:0]      dout_dr,
  output logic signed [15:0]      dout_di,
  output logic                    dout_dv,
  output logic [7:0]              dout_chn,
  output logic                    dout_sof,
  output logic                    dout_eof,
  output logic                    sync_out,
  input  logic                    ctrl_enable [NUM_CHN],
  input  logic [CNT_W-1:0]        ctrl_offset [NUM_CHN],
  input  logic [CNT_W-1:0]        ctrl_length [NUM_CHN],
  input  logic                    ctrl_clear,
  output logic [NUM_CHN-1:0]      stat_trunc
);

  chn_ctx_t ctx      [NUM_CHN];
  chn_ctx_t ctx_next [NUM_CHN];
  chn_ctx_t sel_ctx;
  chn_ctx_t upd_ctx;
  logic     sel_hit;
  logic     pass_now;
  logic     fwd;
  logic     fwd_sof;
  logic     fwd_eof;

  logic [NUM_CHN-1:0] trunc_set;
  logic [NUM_CHN-1:0] trunc_next;

  logic               s1_dv;
  logic               s1_sof;
  logic               s1_eof;
  logic               s1_sync;
  logic signed [15:0] s1_dr;
  logic signed [15:0] s1_di;
  logic [7:0]         s1_chn;

  // Fetch the addressed channel's context; a coincident sync means the sample
  // sees the freshly loaded context. Out-of-range channels never hit.
  always_comb begin
    sel_hit = 1'b0;
    sel_ctx = '0;
    for (int c = 0; c < NUM_CHN; c++) begin
      if (din_dv && din_chn == 8'(c)) begin
        sel_hit = 1'b1;
        sel_ctx = sync_in ? load_ctx(ctrl_enable[c], ctrl_offset[c], ctrl_length[c])
                          : ctx[c];
      end
    end
  end

  // Window decision for the selected sample. A SKIP with nothing left to
  // skip behaves as PASS on the same sample, so the first forwarded sample
  // is always the one taken straight out of SKIP.
  always_comb begin
    upd_ctx  = sel_ctx;
    fwd      = 1'b0;
    fwd_sof  = 1'b0;
    fwd_eof  = 1'b0;
    pass_now = 1'b0;
    case (sel_ctx.state)
      ST_SKIP: begin
        if (sel_ctx.skip != '0) upd_ctx.skip = sel_ctx.skip - CNT_ONE;
        else                    pass_now     = 1'b1;
      end
      ST_PASS: pass_now = 1'b1;
      default: pass_now = 1'b0;
    endcase
    if (pass_now) begin
      if (sel_ctx.rem == '0) begin
        upd_ctx.state = ST_DONE;
      end else begin
        fwd           = sel_hit;
        fwd_sof       = (sel_ctx.state == ST_SKIP);
        fwd_eof       = (sel_ctx.rem == CNT_ONE);
        upd_ctx.rem   = sel_ctx.rem - CNT_ONE;
        upd_ctx.state = (sel_ctx.rem == CNT_ONE) ? ST_DONE : ST_PASS;
      end
    end
  end

  // Next contexts: sync reloads every channel, the addressed channel takes
  // the updated context; any window still open at sync is flagged truncated.
  always_comb begin
    for (int c = 0; c < NUM_CHN; c++) begin
      ctx_next[c] = sync_in ? load_ctx(ctrl_enable[c], ctrl_offset[c], ctrl_length[c])
                            : ctx[c];
      if (sel_hit && din_chn == 8'(c)) ctx_next[c] = upd_ctx;
      trunc_set[c] = sync_in && (ctx[c].state == ST_SKIP || ctx[c].state == ST_PASS);
    end
    trunc_next = (stat_trunc & ~{NUM_CHN{ctrl_clear}}) | trunc_set;
  end

  // Context register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHN; c++) ctx[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHN; c++) ctx[c] <= ctx_next[c];
    end
  end

  // Stage 1: capture forwarding decision, payload, sync and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dv      <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eof     <= 1'b0;
      s1_sync    <= 1'b0;
      s1_dr      <= '0;
      s1_di      <= '0;
      s1_chn     <= '0;
      stat_trunc <= '0;
    end else begin
      s1_dv      <= fwd;
      s1_sof     <= fwd_sof;
      s1_eof     <= fwd_eof;
      s1_sync    <= sync_in;
      stat_trunc <= trunc_next;
      if (fwd) begin
        s1_dr  <= din_dr;
        s1_di  <= din_di;
        s1_chn <= din_chn;
      end
    end
  end

  // Stage 2: output register; payload holds between valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dv  <= 1'b0;
      dout_sof <= 1'b0;
      dout_eof <= 1'b0;
      sync_out <= 1'b0;
      dout_dr  <= '0;
      dout_di  <= '0;
      dout_chn <= '0;
    end else begin
      dout_dv  <= s1_dv;
      dout_sof <= s1_sof;
      dout_eof <= s1_eof;
      sync_out <= s1_sync;
      if (s1_dv) begin
        dout_dr  <= s1_dr;
        dout_di  <= s1_di;
        dout_chn <= s1_chn;
      end
    end
  end

endmodule

// File: tb/tb_prach_window.sv
// Randomized bench for prach_window: a frame-index reference model pushes
// expected outputs into a scoreboard queue, a negedge monitor pops and checks.
module tb_prach_window;

  localparam int NUM = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] din_dr, din_di;
  logic               din_dv;
  logic [7:0]         din_chn;
  logic               sync_in;
  logic signed [15:0] dout_dr, dout_di;
  logic               dout_dv;
  logic [7:0]         dout_chn;
  logic               dout_sof, dout_eof, sync_out;
  logic               ctrl_enable [NUM];
  logic [15:0]        ctrl_offset [NUM];
  logic [15:0]        ctrl_length [NUM];
  logic               ctrl_clear;
  logic [NUM-1:0]     stat_trunc;

  prach_window #(.NUM_CHN(NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .dout_chn(dout_chn),
    .dout_sof(dout_sof), .dout_eof(dout_eof), .sync_out(sync_out),
    .ctrl_enable(ctrl_enable), .ctrl_offset(ctrl_offset), .ctrl_length(ctrl_length),
    .ctrl_clear(ctrl_clear), .stat_trunc(stat_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dr;
    logic [15:0] di;
    logic [7:0]  chn;
    logic        sof;
    logic        eof;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: per channel, frame sample index and the window config
  // captured at the last sync.
  bit             m_act  [NUM];
  int             m_off  [NUM];
  int             m_len  [NUM];
  int             m_seen [NUM];
  logic [NUM-1:0] m_trunc;
  logic [1:0]     sync_hist;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_hist <= 2'b00;
    else        sync_hist <= {sync_hist[0], sync_in};
  end

  // Monitor: check reset values, sync delay, and pop the scoreboard on output.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checks++;
      if ({dout_dv, dout_sof, dout_eof, sync_out} !== 4'b0 || stat_trunc !== '0 ||
          dout_dr !== '0 || dout_di !== '0 || dout_chn !== '0) begin
        errors++;
        $display("FAIL reset_outputs: dv=%b sof=%b eof=%b sync=%b trunc=%h dr=%h di=%h chn=%0d, required all 0",
                 dout_dv, dout_sof, dout_eof, sync_out, stat_trunc, dout_dr, dout_di, dout_chn);
      end
    end else begin
      checks++;
      if (sync_out !== sync_hist[1]) begin
        errors++;
        $display("FAIL sync_out cyc=%0d: got %b required %b", cyc, sync_out, sync_hist[1]);
      end
      if (dout_dv === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d: chn=%0d dr=%h di=%h sof=%b eof=%b, required no output",
                   cyc, dout_chn, dout_dr, dout_di, dout_sof, dout_eof);
        end else begin
          e = q.pop_front();
          if (dout_dr !== e.dr || dout_di !== e.di || dout_chn !== e.chn ||
              dout_sof !== e.sof || dout_eof !== e.eof || cyc != e.due) begin
            errors++;
            $display("FAIL sample cyc=%0d: got chn=%0d dr=%h di=%h sof=%b eof=%b, required cyc=%0d chn=%0d dr=%h di=%h sof=%b eof=%b",
                     cyc, dout_chn, dout_dr, dout_di, dout_sof, dout_eof,
                     e.due, e.chn, e.dr, e.di, e.sof, e.eof);
          end else begin
            $display("OK cyc=%0d chn=%0d dr=%h di=%h sof=%b eof=%b", cyc, dout_chn, dout_dr, dout_di, dout_sof, dout_eof);
          end
        end
      end else begin
        checks++;
        if (dout_sof !== 1'b0 || dout_eof !== 1'b0) begin
          errors++;
          $display("FAIL idle_flags cyc=%0d: sof=%b eof=%b, required 0 0", cyc, dout_sof, dout_eof);
        end
      end
    end
  end

  task automatic model_reset();
    for (int c = 0; c < NUM; c++) begin
      m_act[c] = 1'b0; m_off[c] = 0; m_len[c] = 0; m_seen[c] = 0;
    end
    m_trunc = '0;
    q.delete();
  endtask

  // One input cycle: drive, update the model, advance one clock, check status.
  task automatic step(input logic dv, input int ch, input logic sync, input logic clr);
    logic [NUM-1:0] set;
    exp_t e;
    int n;
    din_dv = dv; din_chn = 8'(ch); sync_in = sync; ctrl_clear = clr;
    din_dr = 16'($urandom); din_di = 16'($urandom);
    set = '0;
    if (sync) begin
      for (int c = 0; c < NUM; c++) begin
        set[c] = m_act[c] && (m_seen[c] < m_off[c] + ((m_len[c] > 0) ? m_len[c] : 1));
        m_act[c]  = ctrl_enable[c];
        m_off[c]  = int'(ctrl_offset[c]);
        m_len[c]  = int'(ctrl_length[c]);
        m_seen[c] = 0;
      end
    end
    if (clr) m_trunc = '0;
    m_trunc = m_trunc | set;
    if (dv && ch < NUM && m_act[ch]) begin
      n = m_seen[ch];
      if (n >= m_off[ch] && n < m_off[ch] + m_len[ch]) begin
        e.dr = din_dr; e.di = din_di; e.chn = 8'(ch);
        e.sof = (n == m_off[ch]);
        e.eof = (n == m_off[ch] + m_len[ch] - 1);
        e.due = cyc + 2;
        q.push_back(e);
      end
      m_seen[ch] = n + 1;
    end
    @(posedge clk); #1;
    if (rst_n) begin
      checks++;
      if (stat_trunc !== m_trunc) begin
        errors++;
        $display("FAIL stat_trunc cyc=%0d: got %b required %b", cyc, stat_trunc, m_trunc);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cfg_all(input logic [7:0] en, input int off, input int len);
    for (int c = 0; c < NUM; c++) begin
      ctrl_enable[c] = en[c];
      ctrl_offset[c] = 16'(off);
      ctrl_length[c] = 16'(len);
    end
  endtask

  task automatic rr(input int n, input logic sync_first);
    for (int i = 0; i < n; i++) step(1'b1, i % NUM, sync_first && i == 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic expect_trunc(input string name, input logic [NUM-1:0] req);
    checks++;
    if (stat_trunc !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, stat_trunc, req);
    end
  endtask

  initial begin
    din_dr = '0; din_di = '0; din_dv = 1'b0; din_chn = '0; sync_in = 1'b0; ctrl_clear = 1'b0;
    cfg_all(8'h00, 0, 0);
    @(posedge clk); #1;
    do_reset(3);

    // No sync yet: nothing may be forwarded even with enabled channels.
    cfg_all(8'hFF, 0, 4);
    rr(16, 1'b0);

    // Channel 0 offset 3 length 4, other channels random windows.
    for (int c = 1; c < NUM; c++) begin
      ctrl_enable[c] = 1'($urandom);
      ctrl_offset[c] = 16'($urandom_range(0, 4));
      ctrl_length[c] = 16'($urandom_range(0, 5));
    end
    ctrl_enable[0] = 1'b1; ctrl_offset[0] = 16'd3; ctrl_length[0] = 16'd4;
    rr(80, 1'b1);
    idle(3);

    // Only channels 0 and 2 enabled, two samples each.
    cfg_all(8'h05, 0, 2);
    rr(40, 1'b1);
    idle(3);

    // Truncate channel 1 mid-window (rem=5), restart, then clear.
    cfg_all(8'h02, 0, 10);
    rr(40, 1'b1);
    rr(1, 1'b1);
    expect_trunc("trunc_set_chn1", 8'h02);
    rr(100, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    expect_trunc("trunc_cleared", 8'h00);

    // Length 0 and length 1 windows.
    cfg_all(8'hFF, 1, 0);
    for (int c = 0; c < NUM; c += 2) ctrl_length[c] = 16'd1;
    rr(40, 1'b1);
    idle(3);

    // Out-of-range channel 9 interleaved, sync coincident with a sample.
    cfg_all(8'hFF, 2, 3);
    step(1'b1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b1, $urandom_range(0, 9), 1'b0, 1'b0);
    idle(3);

    // Reset in the middle of open windows; no output until the next sync.
    cfg_all(8'hFF, 0, 30);
    rr(20, 1'b1);
    do_reset(4);
    rr(40, 1'b0);
    rr(40, 1'b1);

    // Fully random traffic, configs changing mid-frame, random sync/clear.
    for (int i = 0; i < 1500; i++) begin
      int c;
      c = $urandom_range(0, NUM - 1);
      ctrl_enable[c] = 1'($urandom);
      ctrl_offset[c] = 16'($urandom_range(0, 6));
      ctrl_length[c] = 16'($urandom_range(0, 6));
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 10),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
    end
    idle(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outputs still pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
